// File: rtl/nand_prog_target_pkg.sv
// nand_prog_target_pkg: command opcodes and FSM state encodings shared between
// the B-side program target and the page-copy controller.
package nand_prog_target_pkg;

  localparam logic [7:0] CMD_PROG_SETUP   = 8'h80;
  localparam logic [7:0] CMD_PROG_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_STATUS       = 8'h70;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PROG   = 3'd3,
    ST_STATUS = 3'd4
  } nand_state_t;

endpackage

// File: rtl/nand_prog_target_page_buf.sv
// nand_page_buf: one-page byte buffer, single write port and a single read
// port whose data appears one clock after the read address is presented.
module nand_page_buf #(
  parameter int PAGE_BYTES = 512,
  parameter int COL_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [PAGE_BYTES];

  // Storage is never cleared so page contents survive aborts and resets
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; cleared on reset so the store data output starts at zero
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= 8'h00;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nand_prog_target.sv
// nand_prog_target: NAND page-program target on the destination flash bus.
// Collects 0x80/address/data/0x10 sequences into a page buffer, then drains
// the page into a byte-wide backing store while holding F_RB low.
// Define NAND_STATUS_EN to enable the 0x70 status-read command.
module nand_prog_target
  import nand_prog_target_pkg::*;
#(
  parameter int PAGE_BYTES = 512,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 9,
  parameter int T_PROG     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             F_IO,
  input  logic                   F_CLE,
  input  logic                   F_ALE,
  input  logic                   F_WEN,
  input  logic                   F_REN,
  output logic [7:0]             F_IO_OUT,
  output logic                   F_IO_OE,
  output logic                   F_RB,
  output logic                   mem_we,
  output logic [ROW_W+COL_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   prog_err
);

  localparam logic [COL_W:0]     PAGE_CNT   = (COL_W+1)'(PAGE_BYTES);
  localparam int                 TIMER_W    = $clog2(T_PROG + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(T_PROG);
  localparam logic [TIMER_W-1:0] TIMER_DONE = TIMER_W'(T_PROG - 1);

  nand_state_t        state, state_n, ret_state, ret_n;
  logic [1:0]         addr_idx, addr_idx_n;
  logic [COL_W-1:0]   col, col_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [COL_W:0]     count, count_n;
  logic [COL_W:0]     drain_cnt;
  logic [TIMER_W-1:0] timer;
  logic               ready_q;
  logic               buf_we, start_prog, short_err, abort;
  logic               drain_done, prog_release, rd_en;

  wire is_cmd  = ~F_WEN &  F_CLE & ~F_ALE;
  wire is_addr = ~F_WEN & ~F_CLE &  F_ALE;
  wire is_data = ~F_WEN & ~F_CLE & ~F_ALE;

  assign drain_done   = (drain_cnt == PAGE_CNT);
  assign prog_release = ~ready_q & drain_done & (timer >= TIMER_DONE);
  assign rd_en        = ~ready_q & ~drain_done & ~abort;
  assign F_RB         = ready_q;

  nand_page_buf #(
    .PAGE_BYTES(PAGE_BYTES),
    .COL_W     (COL_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (buf_we),
    .wr_addr(col),
    .wr_data(F_IO),
    .rd_en  (rd_en),
    .rd_addr(drain_cnt[COL_W-1:0]),
    .rd_data(mem_wdata)
  );

  // Protocol state, address phase progress, column pointer and page byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      addr_idx  <= 2'd0;
      col       <= '0;
      row       <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      addr_idx  <= addr_idx_n;
      col       <= col_n;
      row       <= row_n;
      count     <= count_n;
    end
  end

  // Decode each sampled bus cycle against the current state; 0xFF wins everywhere
  always_comb begin
    state_n    = state;
    ret_n      = ret_state;
    addr_idx_n = addr_idx;
    col_n      = col;
    row_n      = row;
    count_n    = count;
    buf_we     = 1'b0;
    start_prog = 1'b0;
    short_err  = 1'b0;
    abort      = 1'b0;
    if (is_cmd && F_IO == CMD_RESET) begin
      state_n = ST_IDLE;
      abort   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_cmd && F_IO == CMD_PROG_SETUP) begin
            state_n    = ST_ADDR;
            addr_idx_n = 2'd0;
            count_n    = '0;
          end
`ifdef NAND_STATUS_EN
          if (is_cmd && F_IO == CMD_STATUS) begin
            ret_n   = ST_IDLE;
            state_n = ST_STATUS;
          end
`endif
        end
        ST_ADDR, ST_DATA: begin
          if (is_cmd && F_IO == CMD_PROG_SETUP) begin
            state_n    = ST_ADDR;
            addr_idx_n = 2'd0;
            count_n    = '0;
          end else if (state == ST_ADDR && is_addr) begin
            case (addr_idx)
              2'd0:    col_n[7:0]       = F_IO;
              2'd1:    col_n[COL_W-1:8] = F_IO[COL_W-9:0];
              2'd2:    row_n[7:0]       = F_IO;
              default: row_n[ROW_W-1:8] = F_IO[ROW_W-9:0];
            endcase
            addr_idx_n = addr_idx + 2'd1;
            if (addr_idx == 2'd3) state_n = ST_DATA;
          end else if (state == ST_DATA && is_data) begin
            buf_we = 1'b1;
            col_n  = col + COL_W'(1);
            if (count != PAGE_CNT) count_n = count + (COL_W+1)'(1);
          end else if (state == ST_DATA && is_cmd && F_IO == CMD_PROG_CONFIRM) begin
            if (count == PAGE_CNT) begin
              start_prog = 1'b1;
              state_n    = ST_PROG;
            end else begin
              short_err = 1'b1;
              state_n   = ST_IDLE;
            end
          end
        end
        ST_PROG: begin
          if (prog_release) state_n = ST_IDLE;
`ifdef NAND_STATUS_EN
          if (is_cmd && F_IO == CMD_STATUS) begin
            ret_n   = prog_release ? ST_IDLE : ST_PROG;
            state_n = ST_STATUS;
          end
`endif
        end
        ST_STATUS: begin
          if (prog_release) ret_n = ST_IDLE;
          if (is_cmd) state_n = prog_release ? ST_IDLE : ret_state;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Drain engine: one store write per cycle, busy held for at least T_PROG cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      drain_cnt <= '0;
      timer     <= '0;
      prog_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (abort) begin
        ready_q <= 1'b1;
      end else if (start_prog) begin
        ready_q   <= 1'b0;
        drain_cnt <= '0;
        timer     <= '0;
        prog_err  <= 1'b0;
      end else if (!ready_q) begin
        if (!drain_done) begin
          mem_we    <= 1'b1;
          mem_addr  <= {row, drain_cnt[COL_W-1:0]};
          drain_cnt <= drain_cnt + (COL_W+1)'(1);
        end
        if (timer != TIMER_MAX) timer <= timer + TIMER_W'(1);
        if (prog_release) ready_q <= 1'b1;
      end
      if (short_err) prog_err <= 1'b1;
    end
  end

`ifdef NAND_STATUS_EN
  assign F_IO_OE  = (state == ST_STATUS) && !F_REN;
  assign F_IO_OUT = F_IO_OE ? {ready_q, 6'd0, prog_err} : 8'h00;
`else
  logic unused_ren;
  assign unused_ren = F_REN;
  assign F_IO_OE    = 1'b0;
  assign F_IO_OUT   = 8'h00;
`endif

endmodule

// File: tb/tb_nand_prog_target.sv
// tb_nand_prog_target: randomized self-checking bench for nand_prog_target,
// compared against a page-level model of the buffer and program results.
`timescale 1ns/1ps
module tb_nand_prog_target;

  localparam int PAGE   = 512;
  localparam int T_PROG = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  F_IO = 8'h00;
  logic        F_CLE = 1'b0, F_ALE = 1'b0, F_WEN = 1'b1, F_REN = 1'b1;
  logic [7:0]  F_IO_OUT;
  logic        F_IO_OE, F_RB, mem_we, prog_err;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;

  nand_prog_target #(
    .PAGE_BYTES(PAGE), .COL_W(9), .ROW_W(9), .T_PROG(T_PROG)
  ) dut (
    .clk(clk), .rst(rst), .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE),
    .F_WEN(F_WEN), .F_REN(F_REN), .F_IO_OUT(F_IO_OUT), .F_IO_OE(F_IO_OE),
    .F_RB(F_RB), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int wa_q[$];
  int wd_q[$];
  always @(posedge clk) begin
    #2;
    if (mem_we === 1'b1) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_wdata));
    end
  end

  // Page-level reference model
  int mbuf [PAGE];
  int m_row, m_cnt;
  bit m_prog_err = 1'b0;
  int first_b [3];
  int bad_idx;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int drain_mismatches(input int n);
    int bad = 0;
    int lim = (wa_q.size() < n) ? wa_q.size() : n;
    bad_idx = -1;
    for (int i = 0; i < lim; i++) begin
      if (wa_q[i] != m_row * PAGE + i || wd_q[i] != mbuf[i]) begin
        if (bad_idx < 0) bad_idx = i;
        bad++;
      end
    end
    return bad + (n - lim);
  endfunction

  function automatic string first_bad();
    if (bad_idx < 0) return "missing pulses";
    return $sformatf("idx %0d got addr=%0h data=%0h expected addr=%0h data=%0h",
                     bad_idx, wa_q[bad_idx], wd_q[bad_idx], m_row * PAGE + bad_idx, mbuf[bad_idx]);
  endfunction

  task automatic bus(input logic cle, input logic ale, input logic [7:0] d);
    F_CLE = cle; F_ALE = ale; F_IO = d; F_WEN = 1'b0;
    @(negedge clk);
    F_WEN = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic send_page(input int row, input int col, input int n, input bit patterned, input int noise_at);
    int c, b;
    bus(1'b1, 1'b0, 8'h80);
    bus(1'b0, 1'b1, 8'(col & 255));
    bus(1'b0, 1'b1, 8'((col >> 8) & 1));
    bus(1'b0, 1'b1, 8'(row & 255));
    bus(1'b0, 1'b1, 8'((row >> 8) & 1));
    c = col; m_cnt = 0; m_row = row;
    for (int i = 0; i < n; i++) begin
      if (i == noise_at) bus(1'b1, 1'b1, 8'h10);
      b = patterned ? (i % 256) : int'($urandom_range(0, 255));
      bus(1'b0, 1'b0, 8'(b));
      mbuf[c] = b;
      if (i < 3) first_b[i] = b;
      c = (c + 1) % PAGE;
      if (m_cnt < PAGE) m_cnt++;
    end
  endtask

  task automatic confirm(output int ccyc);
    wa_q.delete(); wd_q.delete();
    bus(1'b1, 1'b0, 8'h10);
    ccyc = cyc;
    m_prog_err = (m_cnt != PAGE);
  endtask

  task automatic wait_ready(input int budget, output bit ok, output int rise_cyc);
    ok = 1'b0; rise_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (F_RB === 1'b1) begin ok = 1'b1; rise_cyc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (F_RB !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rb: got %b want 1", F_RB); end
    n_checks++; if (F_IO_OE !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_oe: got %b want 0", F_IO_OE); end
    n_checks++; if (F_IO_OUT !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out: got %h want 00", F_IO_OUT); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 18'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h want 00", mem_wdata); end
    n_checks++; if (prog_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", prog_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_page();
    int cc, rise, bad; bit ok;
    send_page(5, 0, 512, 1'b1, -1);
    confirm(cc);
    n_checks++; if (F_RB !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy: F_RB=%b want 0", F_RB); end
    wait_ready(3000, ok, rise);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL single_ready: F_RB never rose, want 1 within 3000 cycles"); end
    n_checks++; if (rise - cc < T_PROG) begin n_fail++; $display("[TB] FAIL single_busy_time: %0d cycles, want >= %0d", rise - cc, T_PROG); end
    n_checks++; if (wa_q.size() != PAGE) begin n_fail++; $display("[TB] FAIL single_pulses: %0d want %0d", wa_q.size(), PAGE); end
    bad = drain_mismatches(PAGE);
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL single_drain: %0d bad, %s", bad, first_bad()); end
    n_checks++; if (prog_err !== m_prog_err) begin n_fail++; $display("[TB] FAIL single_err: got %b want %b", prog_err, m_prog_err); end
  endtask

  task automatic test_short_page();
    int cc; bit rb_dropped = 1'b0;
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 100, 1'b0, -1);
    confirm(cc);
    for (int i = 0; i < 20; i++) begin
      if (F_RB !== 1'b1) rb_dropped = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (prog_err !== m_prog_err) begin n_fail++; $display("[TB] FAIL short_err: got %b want %b", prog_err, m_prog_err); end
    n_checks++; if (wa_q.size() != 0) begin n_fail++; $display("[TB] FAIL short_no_write: %0d pulses want 0", wa_q.size()); end
    n_checks++; if (rb_dropped) begin n_fail++; $display("[TB] FAIL short_rb: F_RB went low, want 1 throughout"); end
  endtask

  task automatic test_col_wrap();
    int cc, rise, bad, got0, got1fe; bit ok;
    send_page(int'($urandom_range(0, 511)), 'h1FE, 512, 1'b0, -1);
    confirm(cc);
    wait_ready(3000, ok, rise);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL wrap_ready: F_RB never rose, want 1"); end
    bad = drain_mismatches(PAGE);
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL wrap_drain: %0d bad, %s", bad, first_bad()); end
    got1fe = (wd_q.size() > 'h1FE) ? wd_q['h1FE] : -1;
    got0   = (wd_q.size() > 0) ? wd_q[0] : -1;
    n_checks++; if (got1fe != first_b[0]) begin n_fail++; $display("[TB] FAIL wrap_col1fe: got %0h want %0h", got1fe, first_b[0]); end
    n_checks++; if (got0 != first_b[2]) begin n_fail++; $display("[TB] FAIL wrap_col0: got %0h want %0h", got0, first_b[2]); end
    n_checks++; if (prog_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_err_cleared: got %b want 0", prog_err); end
  endtask

  task automatic test_abort();
    int cc, rise, bad, guard; bit ok;
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 1'b0, -1);
    confirm(cc);
    guard = 0;
    while (wa_q.size() < 200 && guard < 1000) begin @(negedge clk); guard++; end
    n_checks++; if (wa_q.size() < 200) begin n_fail++; $display("[TB] FAIL abort_reach: %0d pulses want 200", wa_q.size()); end
    bus(1'b1, 1'b0, 8'hFF);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_we: got %b want 0", mem_we); end
    n_checks++; if (F_RB !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_rb: got %b want 1", F_RB); end
    repeat (10) @(negedge clk);
    n_checks++; if (wa_q.size() != 200) begin n_fail++; $display("[TB] FAIL abort_pulses: %0d want 200", wa_q.size()); end
    bad = drain_mismatches(200);
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL abort_partial: %0d bad, %s", bad, first_bad()); end
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 1'b0, -1);
    confirm(cc);
    wait_ready(3000, ok, rise);
    n_checks++; if (!ok || wa_q.size() != PAGE) begin n_fail++; $display("[TB] FAIL abort_next_count: ok=%b pulses=%0d want 1/%0d", ok, wa_q.size(), PAGE); end
    bad = drain_mismatches(PAGE);
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL abort_next_drain: %0d bad, %s", bad, first_bad()); end
  endtask

  task automatic test_bus_noise();
    int cc, rise, bad; bit ok; bit rb_dropped = 1'b0;
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 1'b0, 77);
    confirm(cc);
    bus(1'b1, 1'b1, 8'hFF);
    bus(1'b1, 1'b0, 8'h90);
    bus(1'b0, 1'b0, 8'hAA);
    bus(1'b0, 1'b0, 8'h55);
    bus(1'b0, 1'b1, 8'h12);
    bus(1'b1, 1'b0, 8'h80);
    n_checks++; if (F_RB !== 1'b0) begin n_fail++; $display("[TB] FAIL noise_busy: F_RB=%b want 0", F_RB); end
    wait_ready(3000, ok, rise);
    n_checks++; if (!ok || wa_q.size() != PAGE) begin n_fail++; $display("[TB] FAIL noise_count: ok=%b pulses=%0d want 1/%0d", ok, wa_q.size(), PAGE); end
    bad = drain_mismatches(PAGE);
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL noise_drain: %0d bad, %s", bad, first_bad()); end
    wa_q.delete(); wd_q.delete();
    bus(1'b0, 1'b0, 8'h33);
    bus(1'b1, 1'b0, 8'h10);
    bus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (F_RB !== 1'b1) rb_dropped = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (rb_dropped || wa_q.size() != 0) begin n_fail++; $display("[TB] FAIL noise_idle: rb_dropped=%b pulses=%0d want 0/0", rb_dropped, wa_q.size()); end
    n_checks++; if (prog_err !== m_prog_err) begin n_fail++; $display("[TB] FAIL noise_err: got %b want %b", prog_err, m_prog_err); end
  endtask

`ifdef NAND_STATUS_EN
  task automatic test_status();
    int cc, rise, bad; bit ok;
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 1'b0, -1);
    F_REN = 1'b0;
    confirm(cc);
    repeat (5) @(negedge clk);
    bus(1'b1, 1'b0, 8'h70);
    n_checks++; if (F_IO_OE !== 1'b1) begin n_fail++; $display("[TB] FAIL status_oe: got %b want 1", F_IO_OE); end
    n_checks++; if (F_IO_OUT !== {1'b0, 6'd0, m_prog_err}) begin n_fail++; $display("[TB] FAIL status_busy: got %h want %h", F_IO_OUT, {1'b0, 6'd0, m_prog_err}); end
    wait_ready(3000, ok, rise);
    n_checks++; if (F_IO_OUT !== {1'b1, 6'd0, m_prog_err}) begin n_fail++; $display("[TB] FAIL status_ready: got %h want %h", F_IO_OUT, {1'b1, 6'd0, m_prog_err}); end
    bad = drain_mismatches(PAGE);
    n_checks++; if (!ok || bad != 0) begin n_fail++; $display("[TB] FAIL status_drain: ok=%b %0d bad, %s", ok, bad, first_bad()); end
    bus(1'b1, 1'b0, 8'h90);
    #1;
    n_checks++; if (F_IO_OE !== 1'b0) begin n_fail++; $display("[TB] FAIL status_leave: got %b want 0", F_IO_OE); end
    F_REN = 1'b1;
  endtask
`else
  task automatic test_status();
    F_REN = 1'b0;
    bus(1'b1, 1'b0, 8'h70);
    n_checks++; if (F_IO_OE !== 1'b0) begin n_fail++; $display("[TB] FAIL status_off_oe: got %b want 0", F_IO_OE); end
    n_checks++; if (F_IO_OUT !== 8'h00) begin n_fail++; $display("[TB] FAIL status_off_out: got %h want 00", F_IO_OUT); end
    F_REN = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    int cc, guard;
    logic [37:0] rst_vec;
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 10, 1'b0, -1);
    confirm(cc);
    n_checks++; if (prog_err !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_err_set: got %b want 1", prog_err); end
    send_page(int'($urandom_range(0, 511)), 0, 50, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst_vec = {F_RB, F_IO_OE, F_IO_OUT, mem_we, mem_addr, mem_wdata, prog_err};
    n_checks++; if (rst_vec !== {1'b1, 1'b0, 8'h00, 1'b0, 18'h0, 8'h00, 1'b0}) begin n_fail++; $display("[TB] FAIL mid_data_reset: outputs %h want %h", rst_vec, 38'h20_0000_0000); end
    rst = 1'b0; m_prog_err = 1'b0;
    @(negedge clk);
    send_page(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 1'b0, -1);
    confirm(cc);
    guard = 0;
    while (wa_q.size() < 100 && guard < 1000) begin @(negedge clk); guard++; end
    rst = 1'b1;
    @(negedge clk);
    rst_vec = {F_RB, F_IO_OE, F_IO_OUT, mem_we, mem_addr, mem_wdata, prog_err};
    n_checks++; if (rst_vec !== {1'b1, 1'b0, 8'h00, 1'b0, 18'h0, 8'h00, 1'b0}) begin n_fail++; $display("[TB] FAIL mid_prog_reset: outputs %h want %h", rst_vec, 38'h20_0000_0000); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_short_page();
    test_col_wrap();
    test_abort();
    test_bus_noise();
    test_status();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
